lanzones_imem: RTL and testbench
================================

// Module: lanzones_imem
// PURPOSE
//  Instruction memory feeding the lanzones core fetch stage. Answers the core's word-addressed
//  fetches (RAddr/RRdy) with RVld/RData. Owns a program-load port used by the bench/loader to
//  fill the array before execution. Sits directly upstream of the core's FIff capture register.
// PARAMETERS
//  DEPTH   1024          number of 32-bit instruction words (power of 2, >= 2)
//  AW      $clog2(DEPTH) width of the internal array index
//  NOP     32'h0000_0013 word returned for an out-of-range fetch (addi x0,x0,0)
// PORTS
//  clk        in   1   clock
//  rstn       in   1   reset: synchronous, active-low
//  prog_en    in   1   program-load window; 1 = LOAD mode, fetch port idle
//  prog_we    in   1   write strobe, honoured only while prog_en=1
//  prog_addr  in   32  word address of the write
//  prog_data  in   32  instruction word to write
//  prog_cnt   out  AW+1 number of accepted in-range writes since last LOAD entry
//  RAddr      in   32  word address requested by the core (PC, increments by 1)
//  RRdy       in   1   core can accept a word this cycle / requests a fetch
//  RVld       out  1   RData holds a valid instruction
//  RData      out  32  instruction word
//  RErr       out  1   current RData came from an out-of-range address
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state=IDLE, RVld=0, RData=0, RErr=0, prog_cnt=0.
//   Array contents are NOT reset; reset mid-fetch drops the in-flight word, no replay.
//  FSM (one-hot or binary; encoding in package):
//   IDLE  -> LOAD  when prog_en=1. IDLE -> SERVE when prog_en=0 (one cycle after reset).
//   LOAD  -> SERVE when prog_en=0. Stays in LOAD while prog_en=1.
//   SERVE -> LOAD  when prog_en=1; the same edge clears RVld/RErr (outstanding word discarded).
//  LOAD:
//   - prog_en & prog_we & prog_addr<DEPTH: mem[prog_addr[AW-1:0]] <= prog_data; prog_cnt+1.
//   - Out-of-range writes dropped silently, prog_cnt unchanged.
//   - prog_cnt cleared on the IDLE/SERVE->LOAD edge. It saturates at DEPTH.
//   - RVld=0 throughout.
//  SERVE (fetch pipeline, latency 1):
//   - accept = (!RVld | RRdy). When accept=1 and RRdy=1, RAddr is sampled.
//   - On the next edge: RVld=1, RData=mem[RAddr[AW-1:0]], RErr=0.
//   - If RAddr>=DEPTH: RData=NOP and RErr=1.
//   - accept=1 & RRdy=0: RVld<=0 (word consumed, no new request).
//   - Hold: RVld=1 & RRdy=0 keeps RData/RErr stable until consumed.
//   - Transfer = RVld & RRdy. Back-to-back RRdy=1 yields one word per cycle, in address order.
//  prog_we while prog_en=0 is ignored. There is no write/read collision: writes exist only in LOAD.
//  Address compare uses the full 32-bit RAddr/prog_addr; no silent aliasing.
// STRUCTURE
//  lanzones_pkg: LZ_NOP constant, imem_state_t (IDLE/LOAD/SERVE), XLEN=32.
//  lanzones_imem_ram: single sub-module holding DEPTH x 32 array.
//   - 1 sync write port (we, waddr, wdata) and 1 sync read port (re, raddr, rdata).
//   - Read-first behaviour; no reset on the array.
//  Top: FSM, prog_cnt counter, range checks, RVld/RErr output regs, NOP mux.
// TESTING
//  T1 reset:
//   - Hold rstn=0 3 cycles with RRdy=1 -> RVld=0, RData=0, prog_cnt=0.
//   - The first SERVE cycle after release gives RVld=0.
//  T2 load:
//   - prog_en=1, write 0x00500093 @0, 0x00108113 @1, one write @DEPTH -> prog_cnt=2.
//   - The out-of-range write is not stored.
//  T3 stream:
//   - prog_en=0, RRdy=1, RAddr=0,1,2 on consecutive cycles.
//   - RVld=1 from cycle+1, RData=0x00500093, 0x00108113, then mem[2], one word per cycle.
//  T4 backpressure:
//   - Fetch @1, then RRdy=0 for 4 cycles -> RVld=1 and RData=0x00108113 held stable.
//   - RAddr changes are ignored until RRdy=1.
//  T5 out-of-range:
//   - RAddr=DEPTH+5, RRdy=1 -> next cycle RData=0x00000013, RErr=1.
//   - The next in-range fetch clears RErr.
//  T6 reload mid-stream:
//   - With RVld=1, raise prog_en -> RVld=0 next edge and prog_cnt=0.
//   - Rewrite @0 = 0xDEADBEEF, drop prog_en, fetch @0 -> RData=0xDEADBEEF.

Source files
------------

// File: rtl/lanzones_pkg.sv
// Shared types and constants for the lanzones instruction memory.
package lanzones_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] LZ_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } imem_state_t;

endpackage

// File: rtl/lanzones_imem_if.sv
// Fetch bus and program-load port between the core/loader and the instruction memory.
interface lanzones_imem_if #(
    parameter int AW = 10
) ();
    import lanzones_pkg::*;

    logic            prog_en;
    logic            prog_we;
    logic [XLEN-1:0] prog_addr;
    logic [XLEN-1:0] prog_data;
    logic [AW:0]     prog_cnt;

    logic [XLEN-1:0] RAddr;
    logic            RRdy;
    logic            RVld;
    logic [XLEN-1:0] RData;
    logic            RErr;

    modport master (
        output prog_en, prog_we, prog_addr, prog_data, RAddr, RRdy,
        input  prog_cnt, RVld, RData, RErr
    );

    modport slave (
        input  prog_en, prog_we, prog_addr, prog_data, RAddr, RRdy,
        output prog_cnt, RVld, RData, RErr
    );
endinterface

// File: rtl/lanzones_imem_ram.sv
// DEPTH x 32 instruction array: one synchronous write port, one synchronous read-first read port.
module lanzones_imem_ram
    import lanzones_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/lanzones_imem.sv
// Instruction memory: program-load window plus a one-cycle-latency fetch port with backpressure.
module lanzones_imem
    import lanzones_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    lanzones_imem_if.slave        bus
);

    localparam logic [AW:0]     CNT_MAX   = (AW+1)'(DEPTH);
    localparam logic [XLEN-1:0] DEPTH_LIM = XLEN'(DEPTH);

    imem_state_t     state, state_nxt;
    logic            vld_p1, err_p1;
    logic [XLEN-1:0] rdata_p1;
    logic [AW:0]     cnt;

    logic            wr_en, rd_en, cnt_clr, serving, accept;
    logic            prog_in_range, rd_in_range;

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Full-width compares so that high address bits never alias into the array.
    assign prog_in_range = (bus.prog_addr < DEPTH_LIM);
    assign rd_in_range   = (bus.RAddr < DEPTH_LIM);

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        cnt_clr   = 1'b0;
        serving   = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = bus.prog_en ? LOAD : SERVE;
                cnt_clr   = bus.prog_en;
            end
            LOAD: begin
                state_nxt = bus.prog_en ? LOAD : SERVE;
                wr_en     = bus.prog_en & bus.prog_we & prog_in_range;
            end
            SERVE: begin
                state_nxt = bus.prog_en ? LOAD : SERVE;
                cnt_clr   = bus.prog_en;
                serving   = !bus.prog_en;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = !vld_p1 | bus.RRdy;
    assign rd_en  = serving & bus.RRdy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (wr_en) begin
            cnt <= sat_inc(cnt);
        end
    end

    // Stage p1: fetched word and its status; leaving SERVE discards any outstanding word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (!serving) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= bus.RRdy;
            err_p1 <= bus.RRdy & !rd_in_range;
        end
    end

    lanzones_imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (bus.prog_addr[AW-1:0]),
        .wdata (bus.prog_data),
        .re    (rd_en),
        .raddr (bus.RAddr[AW-1:0]),
        .rdata (rdata_p1)
    );

    // The array is not reset, so RData is forced to zero whenever no word is valid.
    assign bus.RData    = vld_p1 ? (err_p1 ? LZ_NOP : rdata_p1) : '0;
    assign bus.RVld     = vld_p1;
    assign bus.RErr     = err_p1;
    assign bus.prog_cnt = cnt;

endmodule

// File: tb/tb_lanzones_imem.sv
// Directed bench for lanzones_imem: reset, load, streaming, backpressure, out-of-range and reload.
module tb_lanzones_imem;
    import lanzones_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [31:0] W0 = 32'h0050_0093;
    localparam logic [31:0] W1 = 32'h0010_8113;
    localparam logic [31:0] W2 = 32'h0000_0213;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    lanzones_imem_if #(.AW(AW)) bus ();

    lanzones_imem #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn          = 1'b0;
        bus.prog_en   = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.RAddr     = '0;
        bus.RRdy      = 1'b1;

        // T1 reset
        repeat (3) tick();
        chk("rst_rvld", 32'(bus.RVld), 32'd0);
        chk("rst_rdata", bus.RData, 32'd0);
        chk("rst_cnt", 32'(bus.prog_cnt), 32'd0);
        chk("rst_rerr", 32'(bus.RErr), 32'd0);
        rstn = 1'b1;
        tick();
        chk("first_serve_rvld", 32'(bus.RVld), 32'd0);

        // T2 load
        bus.RRdy    = 1'b0;
        bus.prog_en = 1'b1;
        tick();
        bus.prog_we = 1'b1;
        bus.prog_addr = 32'd0;  bus.prog_data = W0;           tick();
        bus.prog_addr = 32'd1;  bus.prog_data = W1;           tick();
        bus.prog_addr = DEPTH;  bus.prog_data = 32'hFFFF_FFFF; tick();
        chk("load_cnt2", 32'(bus.prog_cnt), 32'd2);
        chk("load_rvld", 32'(bus.RVld), 32'd0);
        bus.prog_addr = 32'd2;  bus.prog_data = W2;           tick();
        bus.prog_we = 1'b0;
        chk("load_cnt3", 32'(bus.prog_cnt), 32'd3);

        // T3 stream
        bus.prog_en = 1'b0;
        bus.RRdy    = 1'b1;
        bus.RAddr   = 32'd0;
        tick();
        chk("serve_entry_rvld", 32'(bus.RVld), 32'd0);
        tick();
        chk("stream0_rvld", 32'(bus.RVld), 32'd1);
        chk("stream0_data", bus.RData, W0);
        bus.RAddr = 32'd1; tick();
        chk("stream1_data", bus.RData, W1);
        bus.RAddr = 32'd2; tick();
        chk("stream2_data", bus.RData, W2);
        chk("stream2_rerr", 32'(bus.RErr), 32'd0);

        // T4 backpressure
        bus.RAddr = 32'd1; tick();
        chk("bp_fetch_data", bus.RData, W1);
        bus.RRdy  = 1'b0;
        bus.RAddr = 32'd7;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_rvld", 32'(bus.RVld), 32'd1);
            chk("bp_hold_data", bus.RData, W1);
        end
        bus.RRdy  = 1'b1;
        bus.RAddr = 32'd2;
        tick();
        chk("bp_release_data", bus.RData, W2);

        // T5 out-of-range
        bus.RAddr = DEPTH + 5; tick();
        chk("oor_data", bus.RData, LZ_NOP);
        chk("oor_rerr", 32'(bus.RErr), 32'd1);
        chk("oor_rvld", 32'(bus.RVld), 32'd1);
        bus.RAddr = 32'd0; tick();
        chk("oor_clear_rerr", 32'(bus.RErr), 32'd0);
        chk("oor_no_alias", bus.RData, W0);
        bus.RRdy = 1'b0; tick();
        chk("hold_before_reload", 32'(bus.RVld), 32'd1);

        // T6 reload mid-stream
        bus.prog_en = 1'b1; tick();
        chk("reload_rvld", 32'(bus.RVld), 32'd0);
        chk("reload_cnt", 32'(bus.prog_cnt), 32'd0);
        bus.prog_we = 1'b1; bus.prog_addr = 32'd0; bus.prog_data = 32'hDEAD_BEEF; tick();
        bus.prog_we = 1'b0;
        chk("reload_cnt1", 32'(bus.prog_cnt), 32'd1);
        bus.prog_en = 1'b0;
        bus.RRdy    = 1'b1;
        bus.RAddr   = 32'd0;
        tick();
        tick();
        chk("reload_data", bus.RData, 32'hDEAD_BEEF);
        bus.RAddr = 32'd1; tick();
        chk("reload_keep1", bus.RData, W1);

        // Writes outside LOAD must be ignored
        bus.prog_we = 1'b1; bus.prog_addr = 32'd1; bus.prog_data = 32'h1234_5678; tick();
        bus.prog_we = 1'b0; tick();
        chk("serve_we_ignored", bus.RData, W1);
        chk("serve_we_cnt", 32'(bus.prog_cnt), 32'd1);

        // Reset mid-fetch drops the word
        rstn = 1'b0; tick();
        chk("midrst_rvld", 32'(bus.RVld), 32'd0);
        chk("midrst_rdata", bus.RData, 32'd0);
        chk("midrst_cnt", 32'(bus.prog_cnt), 32'd0);
        rstn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
